// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and command-format definitions for the ALU command issuer.
// Imported by the FIFO and the top so both agree on the packed {op,b,a} layout.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [11:0] DIV0_RESULT = 12'hFFF;
  localparam int          CMD_W       = 14;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] b;
    logic [5:0] a;
  } cmd_t;

  function automatic logic is_div0(input cmd_t cmd);
    return (cmd.op == OP_DIV) && (cmd.b == 6'd0);
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command and response channels of the ALU command issuer.
// The issuer itself is the slave; whoever feeds commands and drains responses is the master.
interface alu_cmd_issuer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_a;
  logic [5:0]  cmd_b;
  logic [1:0]  cmd_op;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [11:0] rsp_c;
  logic        rsp_ovf;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_c, rsp_ovf, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    output cmd_ready, rsp_valid, rsp_c, rsp_ovf, rsp_err
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO holding queued ALU commands; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = CMD_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues buffered commands to a combinational 6-bit ALU one at a time and returns
// results in order; divide-by-zero is answered locally without touching the ALU.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_cmd_issuer_if.slave   bus,
  output logic [5:0]        alu_a,
  output logic [5:0]        alu_b,
  output logic [1:0]        alu_op,
  input  logic [11:0]       alu_c,
  input  logic              alu_ovf,
  output logic [CNT_W-1:0]  ovf_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [5:0]        alu_a_q, alu_a_d;
  logic [5:0]        alu_b_q, alu_b_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [11:0]       rsp_c_q, rsp_c_d;
  logic              rsp_ovf_q, rsp_ovf_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CMD_W-1:0]  fifo_dout;
  logic              pop;
  logic              hs;
  logic              head_div0;
  cmd_t              head;

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.cmd_valid),
    .din   ({bus.cmd_op, bus.cmd_b, bus.cmd_a}),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign head      = cmd_t'(fifo_dout);
  assign head_div0 = is_div0(head);
  assign hs        = rsp_valid_q && bus.rsp_ready;
  // A completed handshake in HOLD frees the slot just like IDLE does.
  assign pop       = !fifo_empty &&
                     ((state_q == S_IDLE) || ((state_q == S_HOLD) && hs));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (pop) state_d = head_div0 ? S_HOLD : S_DRIVE;
      S_DRIVE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_HOLD;
      S_HOLD: begin
        if (hs) begin
          if (pop) state_d = head_div0 ? S_HOLD : S_DRIVE;
          else     state_d = S_IDLE;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_c_d     = rsp_c_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    if (hs) begin
      rsp_valid_d = 1'b0;
      if (rsp_ovf_q && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
    end

    if (pop) begin
      if (head_div0) begin
        rsp_c_d     = DIV0_RESULT;
        rsp_ovf_d   = 1'b0;
        rsp_err_d   = 1'b1;
        rsp_valid_d = 1'b1;
      end else begin
        alu_a_d  = head.a;
        alu_b_d  = head.b;
        alu_op_d = head.op;
      end
    end

    if (state_q == S_CAPTURE) begin
      rsp_c_d     = alu_c;
      rsp_ovf_d   = alu_ovf;
      rsp_err_d   = 1'b0;
      rsp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_c_q     <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_c_q     <= rsp_c_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.cmd_ready = !fifo_full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_err   = rsp_err_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;
  assign ovf_count     = cnt_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer: directed commands push hand-computed results,
// a negedge monitor pops and compares every accepted response.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  typedef struct packed {
    logic [11:0] c;
    logic        ovf;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  alu_a;
  logic [5:0]  alu_b;
  logic [1:0]  alu_op;
  logic [11:0] alu_c;
  logic        alu_ovf;
  logic [7:0]  ovf_count;
  logic [6:0]  alu_tmp;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  rsp_t expq[$];
  int   hsq[$];

  alu_cmd_issuer_if bus ();

  alu_cmd_issuer #(
    .DEPTH (4),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_c     (alu_c),
    .alu_ovf   (alu_ovf),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Combinational ALU: add/sub 6-bit with signed overflow, mul/div unsigned.
  always_comb begin
    alu_tmp = 7'd0;
    alu_c   = 12'd0;
    alu_ovf = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_tmp = {1'b0, alu_a} + {1'b0, alu_b};
        alu_c   = {6'd0, alu_tmp[5:0]};
        alu_ovf = (alu_a[5] == alu_b[5]) && (alu_tmp[5] != alu_a[5]);
      end
      OP_SUB: begin
        alu_tmp = {1'b0, alu_a} - {1'b0, alu_b};
        alu_c   = {6'd0, alu_tmp[5:0]};
        alu_ovf = (alu_a[5] != alu_b[5]) && (alu_tmp[5] != alu_a[5]);
      end
      OP_MUL: alu_c = {6'd0, alu_a} * {6'd0, alu_b};
      default: alu_c = (alu_b == 6'd0) ? 12'd0 : {6'd0, alu_a / alu_b};
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op,
                               input logic [11:0] c, input logic ovf, input logic err);
    bit ok = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      expq.push_back({c, ovf, err});
      @(posedge clk);
      #1;
    end else begin
      total++;
      bad++;
      $display("[TB] FAIL push_timeout: got cmd_ready=0 expected 1");
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (expq.size() == 0) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: got %0d pending expected 0", name, expq.size());
    end
  endtask

  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_rsp: got c=%0h expected none", bus.rsp_c);
        end else begin
          e = expq.pop_front();
          checkOutput("rsp", 32'({bus.rsp_c, bus.rsp_ovf, bus.rsp_err}), 32'(e));
          hsq.push_back(cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_op    = '0;
    bus.rsp_ready = 1'b1;
    rst_n         = 1'b0;
    #1;
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_rsp", 32'({bus.rsp_c, bus.rsp_ovf, bus.rsp_err}), 32'd0);
    checkOutput("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
    checkOutput("rst_ovf_count", 32'(ovf_count), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // add 5+3 with latency measurement
    applyStimulus(6'd5, 6'd3, OP_ADD, 12'h008, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.rsp_valid) break;
    end
    checkOutput("latency", 32'(n), 32'd3);
    checkOutput("alu_regs_add", 32'({alu_a, alu_b, alu_op}), 32'({6'd5, 6'd3, OP_ADD}));
    waitDrain("drain_add");

    applyStimulus(6'h20, 6'h01, OP_SUB, 12'h01F, 1'b1, 1'b0);
    waitDrain("drain_sub");
    checkOutput("ovf_count_1", 32'(ovf_count), 32'd1);

    // divide by zero must not disturb the ALU operand registers
    applyStimulus(6'd9, 6'd0, OP_DIV, 12'hFFF, 1'b0, 1'b1);
    waitDrain("drain_div0");
    checkOutput("alu_kept", 32'({alu_a, alu_b, alu_op}), 32'({6'h20, 6'h01, OP_SUB}));

    // backpressure: five accepted, sixth refused, head response held
    bus.rsp_ready = 1'b0;
    applyStimulus(6'd1,  6'd2, OP_ADD, 12'h003, 1'b0, 1'b0);
    applyStimulus(6'd10, 6'd4, OP_SUB, 12'h006, 1'b0, 1'b0);
    applyStimulus(6'd7,  6'd9, OP_MUL, 12'h03F, 1'b0, 1'b0);
    applyStimulus(6'd20, 6'd3, OP_DIV, 12'h006, 1'b0, 1'b0);
    applyStimulus(6'h1F, 6'd1, OP_ADD, 12'h020, 1'b1, 1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 6'd2;
    bus.cmd_b     = 6'd2;
    bus.cmd_op    = OP_ADD;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      checkOutput("held_rsp", 32'({bus.rsp_valid, bus.rsp_c}), 32'({1'b1, 12'h003}));
    end
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    hsq.delete();
    bus.rsp_ready = 1'b1;
    waitDrain("drain_burst");
    checkOutput("burst_count", 32'(hsq.size()), 32'd5);
    for (int i = 1; i < hsq.size(); i++) begin
      checkOutput("burst_gap", 32'(hsq[i] - hsq[i-1]), 32'd3);
    end
    checkOutput("ovf_count_2", 32'(ovf_count), 32'd2);

    // reset while the first command is being driven, a second still queued
    applyStimulus(6'd3, 6'd4, OP_ADD, 12'h007, 1'b0, 1'b0);
    applyStimulus(6'd1, 6'd1, OP_ADD, 12'h002, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expq.delete();
    checkOutput("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("mid_rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
    checkOutput("mid_rst_rsp", 32'({bus.rsp_c, bus.rsp_ovf, bus.rsp_err}), 32'd0);
    checkOutput("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("mid_rst_ovf_count", 32'(ovf_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(6'h0A, 6'h05, OP_SUB, 12'h005, 1'b0, 1'b0);
    waitDrain("drain_post_rst");

    for (int i = 0; i < 257; i++) begin
      applyStimulus(6'h20, 6'h01, OP_SUB, 12'h01F, 1'b1, 1'b0);
    end
    waitDrain("drain_sat");
    checkOutput("ovf_count_sat", 32'(ovf_count), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
